// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the FSM state encoding, default parameters and byte width.
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int IDX_W              = 3;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 600000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART transmit arbiter.
// slave: arbiter side; master: requesters + transmitter side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*BYTE_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      tx_start;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_done;
    logic                      busy;
    logic [IDX_W-1:0]          owner;
    logic                      err_timeout;

    modport slave (
        input  req, req_data, tx_done,
        output grant, tx_start, tx_data, busy, owner, err_timeout
    );

    modport master (
        output req, req_data, tx_done,
        input  grant, tx_start, tx_data, busy, owner, err_timeout
    );

endinterface

// File: rtl/rr_select.sv
// Round-robin picker: first requester after last_grant, wrapping.
// Ports: req, last_grant in; sel (one-hot), sel_idx, valid out.
module rr_select
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] sel,
    output logic [IDX_W-1:0]   sel_idx,
    output logic               valid
);

    // Two passes: indices above last_grant first, then wrap to the
    // low end (which includes last_grant itself, taken last).
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        valid   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i] && i > int'(last_grant)) begin
                valid   = 1'b1;
                sel[i]  = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i] && i <= int'(last_grant)) begin
                valid   = 1'b1;
                sel[i]  = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters.
// Ports: clk, rst (async, active-low), bus (uart_tx_arbiter_if.slave).
// Option: UART_TX_ARB_TIMEOUT_EN adds a per-byte abort timer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [NUM_REQ-1:0] sel_oh;
    logic [IDX_W-1:0]   sel_idx;
    logic               any_req;
    logic [BYTE_W-1:0]  sel_data;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   owner_q;
    logic [BYTE_W-1:0]  data_q;
    logic               timeout_hit;
    logic               arb_win;

    rr_select #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr (
        .req        (bus.req),
        .last_grant (last_q),
        .sel        (sel_oh),
        .sel_idx    (sel_idx),
        .valid      (any_req)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_oh[i]) begin
                sel_data = sel_data | bus.req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Cleared in LAUNCH, so it reads n-1 in WAIT_DONE cycle n.
    assign timeout_hit = (state == WAIT_DONE) && !bus.tx_done &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state == LAUNCH) begin
                cnt_q <= '0;
            end else if (state == WAIT_DONE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done || timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign arb_win = (state == IDLE) && any_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            data_q  <= '0;
        end else begin
            state <= state_nx;
            if (arb_win) begin
                gnt_q   <= sel_oh;
                last_q  <= sel_idx;
                owner_q <= sel_idx;
                data_q  <= sel_data;
            end
        end
    end

    // grant/tx_start are decoded from LAUNCH so they last exactly
    // one cycle; tx_data/owner keep their latch until the next win.
    assign bus.grant    = (state == LAUNCH) ? gnt_q : '0;
    assign bus.tx_start = (state == LAUNCH);
    assign bus.busy     = (state != IDLE);
    assign bus.tx_data  = data_q;
    assign bus.owner    = owner_q;

endmodule
